// File: rtl/note_field.sv
// note_field: multi-lane falling-note playfield.
// Holds one note per lane, advances live notes on frame_tick, scores button
// presses against a hit window around HIT_Y, and reports with a fixed two-cycle
// latency whether the current pixel lies inside any live note.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   frame_tick           one-cycle pulse per video frame
//   spawn[NUM_LANES]     start a note at the top of an idle lane
//   button[NUM_LANES]    edge-detected press pulses
//   curr_x, curr_y       current VGA pixel
//   in_note, in_lane     pixel inside a note / lowest such lane (latency 2)
//   hit, miss            registered one-cycle pulses per lane
//   active               lane holds a live note
//   score                saturating count of hits
module note_field #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned LANE_X0    = 160,
    parameter int unsigned LANE_PITCH = 80,
    parameter int unsigned NOTE_W     = 40,
    parameter int unsigned SPEED      = 4,
    parameter int unsigned HIT_Y      = 400,
    parameter int unsigned HIT_TOL    = 16,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned SCORE_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [NUM_LANES-1:0] spawn,
    input  logic [NUM_LANES-1:0] button,
    input  logic [9:0]           curr_x,
    input  logic [8:0]           curr_y,
    output logic                 in_note,
    output logic [2:0]           in_lane,
    output logic [NUM_LANES-1:0] hit,
    output logic [NUM_LANES-1:0] miss,
    output logic [NUM_LANES-1:0] active,
    output logic [SCORE_W-1:0]   score
);

    // Lower window bound clamps at zero when HIT_TOL exceeds HIT_Y.
    localparam int unsigned WIN_LO = (HIT_Y > HIT_TOL) ? (HIT_Y - HIT_TOL) : 0;
    localparam int unsigned WIN_HI = HIT_Y + HIT_TOL;
    localparam int unsigned SUM_W  = SCORE_W + 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic {
        LANE_IDLE = 1'b0,
        LANE_LIVE = 1'b1
    } lane_state_e;

    lane_state_e          state_q  [NUM_LANES];
    lane_state_e          state_d  [NUM_LANES];
    logic [8:0]           note_y_q [NUM_LANES];
    logic [8:0]           note_y_d [NUM_LANES];
    logic [9:0]           next_y   [NUM_LANES];
    logic [NUM_LANES-1:0] in_win;
    logic [NUM_LANES-1:0] hit_q, hit_d;
    logic [NUM_LANES-1:0] miss_q, miss_d;
    logic [NUM_LANES-1:0] inside_q, inside_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           hit_cnt;
    logic [SUM_W-1:0]     score_sum;
    logic                 in_note_q, in_note_d;
    logic [2:0]           in_lane_q, in_lane_d;

    // Lane FSMs: hit is judged on the pre-tick position and beats miss.
    always_comb begin
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            state_d[i]  = state_q[i];
            note_y_d[i] = note_y_q[i];
            hit_d[i]    = 1'b0;
            miss_d[i]   = 1'b0;
            next_y[i]   = 10'(note_y_q[i]) + 10'(SPEED);
            in_win[i]   = (11'(note_y_q[i]) >= 11'(WIN_LO)) &&
                          (11'(note_y_q[i]) <= 11'(WIN_HI));
            case (state_q[i])
                LANE_IDLE: begin
                    if (spawn[i]) begin
                        state_d[i]  = LANE_LIVE;
                        note_y_d[i] = 9'd0;
                    end
                end
                LANE_LIVE: begin
                    if (button[i] && in_win[i]) begin
                        state_d[i] = LANE_IDLE;
                        hit_d[i]   = 1'b1;
                    end else if (frame_tick) begin
                        if (next_y[i] >= 10'(SCREEN_H)) begin
                            state_d[i] = LANE_IDLE;
                            miss_d[i]  = 1'b1;
                        end else begin
                            note_y_d[i] = next_y[i][8:0];
                        end
                    end
                end
            endcase
        end
    end

    // Score adds every lane that hit this cycle, saturating at all ones.
    always_comb begin
        hit_cnt = 4'd0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            hit_cnt = hit_cnt + 4'(hit_d[i]);
        end
        score_sum = SUM_W'(score_q) + SUM_W'(hit_cnt);
        if (score_sum > SUM_W'(SCORE_MAX)) begin
            score_d = SCORE_MAX;
        end else begin
            score_d = SCORE_W'(score_sum);
        end
    end

    // Pixel stage 1: strict per-lane inside test against current lane state.
    always_comb begin
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            inside_d[i] = (state_q[i] == LANE_LIVE) &&
                          (11'(curr_x) > 11'(LANE_X0 + i * LANE_PITCH)) &&
                          (11'(curr_x) < 11'(LANE_X0 + i * LANE_PITCH + NOTE_W)) &&
                          (10'(curr_y) > 10'(note_y_q[i])) &&
                          (10'(curr_y) < 10'(note_y_q[i]) + 10'(NOTE_W));
        end
    end

    // Pixel stage 2: lowest-index lane wins.
    always_comb begin
        in_note_d = |inside_q;
        in_lane_d = 3'd0;
        for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
            if (inside_q[i]) begin
                in_lane_d = 3'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                state_q[i]  <= LANE_IDLE;
                note_y_q[i] <= 9'd0;
            end
            hit_q     <= '0;
            miss_q    <= '0;
            score_q   <= '0;
            inside_q  <= '0;
            in_note_q <= 1'b0;
            in_lane_q <= 3'd0;
        end else begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                state_q[i]  <= state_d[i];
                note_y_q[i] <= note_y_d[i];
            end
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            score_q   <= score_d;
            inside_q  <= inside_d;
            in_note_q <= in_note_d;
            in_lane_q <= in_lane_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            active[i] = (state_q[i] == LANE_LIVE);
        end
    end

    assign hit     = hit_q;
    assign miss    = miss_q;
    assign score   = score_q;
    assign in_note = in_note_q;
    assign in_lane = in_lane_q;

endmodule

// File: tb/tb_note_field.sv
// Bench for note_field: directed playfield scenarios followed by random
// traffic, all checked every cycle against a behavioural lane model. A second
// instance with a 2-bit score shares the inputs to exercise saturation.
module tb_note_field;

    localparam int NL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] spawn = 4'd0;
    logic [3:0] button = 4'd0;
    logic [9:0] curr_x = 10'd0;
    logic [8:0] curr_y = 9'd0;

    logic        in_note, in_note2;
    logic [2:0]  in_lane, in_lane2;
    logic [3:0]  hit, miss, active, hit2, miss2, active2;
    logic [15:0] score;
    logic [1:0]  score2;

    always #5 clk = ~clk;

    note_field dut (
        .clock(clk), .reset(reset), .frame_tick(frame_tick), .spawn(spawn),
        .button(button), .curr_x(curr_x), .curr_y(curr_y), .in_note(in_note),
        .in_lane(in_lane), .hit(hit), .miss(miss), .active(active), .score(score)
    );

    note_field #(.SCORE_W(2)) dut2 (
        .clock(clk), .reset(reset), .frame_tick(frame_tick), .spawn(spawn),
        .button(button), .curr_x(curr_x), .curr_y(curr_y), .in_note(in_note2),
        .in_lane(in_lane2), .hit(hit2), .miss(miss2), .active(active2), .score(score2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane_x(input int l);
        return 160 + 80 * l;
    endfunction

    // Behavioural model: lanes as (live, y) pairs, pixel answer through a
    // two-entry delay line.
    bit        m_valid = 0;
    bit  [3:0] m_act;
    int        m_y [NL];
    int        m_score, m_score2;
    bit  [3:0] exp_hit, exp_miss;
    bit        pend_note, exp_note;
    int        pend_lane, exp_lane;

    always @(posedge clk) begin : model
        int  px, py, nhits;
        bit  inn;
        int  inl;
        px = int'(curr_x);
        py = int'(curr_y);
        if (reset) begin
            m_valid   = 1;
            m_act     = 4'd0;
            for (int l = 0; l < NL; l++) m_y[l] = 0;
            m_score   = 0;
            m_score2  = 0;
            exp_hit   = 4'd0;
            exp_miss  = 4'd0;
            pend_note = 0;
            pend_lane = 0;
            exp_note  = 0;
            exp_lane  = 0;
        end else begin
            exp_note = pend_note;
            exp_lane = pend_lane;
            inn = 0;
            inl = 0;
            for (int l = NL - 1; l >= 0; l--) begin
                if (m_act[l] && px > lane_x(l) && px < lane_x(l) + 40 &&
                    py > m_y[l] && py < m_y[l] + 40) begin
                    inn = 1;
                    inl = l;
                end
            end
            pend_note = inn;
            pend_lane = inl;
            exp_hit  = 4'd0;
            exp_miss = 4'd0;
            nhits    = 0;
            for (int l = 0; l < NL; l++) begin
                if (m_act[l]) begin
                    if (button[l] && m_y[l] >= 384 && m_y[l] <= 416) begin
                        m_act[l]   = 0;
                        exp_hit[l] = 1;
                        nhits++;
                    end else if (frame_tick) begin
                        if (m_y[l] + 4 >= 480) begin
                            m_act[l]    = 0;
                            exp_miss[l] = 1;
                        end else begin
                            m_y[l] = m_y[l] + 4;
                        end
                    end
                end else if (spawn[l]) begin
                    m_act[l] = 1;
                    m_y[l]   = 0;
                end
            end
            m_score  = (m_score + nhits > 65535) ? 65535 : m_score + nhits;
            m_score2 = (m_score2 + nhits > 3) ? 3 : m_score2 + nhits;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("hit",     int'(hit),     int'(exp_hit));
            chk("miss",    int'(miss),    int'(exp_miss));
            chk("active",  int'(active),  int'(m_act));
            chk("score",   int'(score),   m_score);
            chk("in_note", int'(in_note), int'(exp_note));
            chk("in_lane", int'(in_lane), exp_lane);
            chk("hit2",    int'(hit2),    int'(exp_hit));
            chk("miss2",   int'(miss2),   int'(exp_miss));
            chk("score2",  int'(score2),  m_score2);
            chk("in_note2", int'(in_note2), int'(exp_note));
        end
    end

    task automatic cyc(input bit rst, input bit tk, input logic [3:0] sp,
                       input logic [3:0] bt, input int x, input int y);
        @(negedge clk);
        reset      = rst;
        frame_tick = tk;
        spawn      = sp;
        button     = bt;
        curr_x     = 10'(x);
        curr_y     = 9'(y);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 4'd0, 4'd0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(0, 1, 4'd0, 4'd0, 0, 0);
    endtask

    initial begin
        logic [3:0] sp, bt;
        int         x, y, l;

        cyc(1, 0, 4'd0, 4'd0, 0, 0);
        cyc(1, 0, 4'd0, 4'd0, 0, 0);
        idle(1);
        chk("lit_reset_active", int'(active), 0);
        chk("lit_reset_score", int'(score), 0);
        chk("lit_reset_in_note", int'(in_note), 0);

        // Lane 0 falls to the hit line and is hit there.
        cyc(0, 0, 4'b0001, 4'd0, 0, 0);
        idle(1);
        chk("lit_spawn0_active", int'(active), 1);
        ticks(100);
        cyc(0, 0, 4'd0, 4'd0, 181, 401);
        idle(2);
        chk("lit_y400_in_note", int'(in_note), 1);
        chk("lit_y400_in_lane", int'(in_lane), 0);
        cyc(0, 0, 4'd0, 4'b0001, 0, 0);
        idle(1);
        chk("lit_hit0", int'(hit), 1);
        chk("lit_hit0_score", int'(score), 1);
        chk("lit_hit0_active", int'(active), 0);
        cyc(0, 0, 4'd0, 4'd0, 181, 420);
        idle(2);
        chk("lit_after_hit_in_note", int'(in_note), 0);

        // Lane 1: early press ignored, then expires at y=480.
        cyc(0, 0, 4'b0010, 4'd0, 0, 0);
        ticks(50);
        cyc(0, 0, 4'd0, 4'b0010, 0, 0);
        idle(1);
        chk("lit_early_press_hit", int'(hit), 0);
        chk("lit_early_press_active", int'(active), 2);
        ticks(70);
        idle(1);
        chk("lit_miss1", int'(miss), 2);
        chk("lit_miss1_active", int'(active), 0);
        chk("lit_miss1_score", int'(score), 1);

        // Lane 2 at y=100: strict pixel edges.
        cyc(0, 0, 4'b0100, 4'd0, 0, 0);
        ticks(25);
        cyc(0, 0, 4'd0, 4'd0, 321, 101);
        cyc(0, 0, 4'd0, 4'd0, 320, 101);
        cyc(0, 0, 4'd0, 4'd0, 321, 140);
        chk("lit_px_inside", int'(in_note), 1);
        chk("lit_px_lane2", int'(in_lane), 2);
        idle(1);
        chk("lit_px_left_edge", int'(in_note), 0);
        idle(1);
        chk("lit_px_bottom_edge", int'(in_note), 0);

        // Lane 3 at the low window edge: tick, press and spawn together.
        cyc(0, 0, 4'b1000, 4'd0, 0, 0);
        ticks(96);
        cyc(0, 1, 4'b1000, 4'b1000, 0, 0);
        idle(1);
        chk("lit_hit3", int'(hit), 8);
        chk("lit_hit3_miss", int'(miss), 0);
        chk("lit_hit3_score", int'(score), 2);
        idle(1);
        chk("lit_spawn_ignored", int'(active), 0);

        // Four simultaneous hits: wide score 6, narrow score saturates at 3.
        cyc(0, 0, 4'b1111, 4'd0, 0, 0);
        ticks(96);
        cyc(0, 0, 4'd0, 4'b1111, 0, 0);
        idle(1);
        chk("lit_multi_hit", int'(hit), 15);
        chk("lit_multi_score", int'(score), 6);
        chk("lit_sat_score2", int'(score2), 3);

        // Reset on the cycle every note would have expired.
        cyc(0, 0, 4'b1111, 4'd0, 0, 0);
        ticks(119);
        cyc(1, 1, 4'd0, 4'd0, 0, 0);
        idle(1);
        chk("lit_rst_miss", int'(miss), 0);
        chk("lit_rst_active", int'(active), 0);
        chk("lit_rst_score", int'(score), 0);
        chk("lit_rst_score2", int'(score2), 0);

        // Random traffic.
        repeat (4000) begin
            sp = 4'd0;
            bt = 4'd0;
            for (int k = 0; k < NL; k++) begin
                sp[k] = ($urandom_range(0, 15) == 0);
                bt[k] = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 1) == 0) begin
                l = $urandom_range(0, NL - 1);
                x = lane_x(l) + $urandom_range(0, 40);
                y = m_y[l] + $urandom_range(0, 40);
            end else begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 511);
            end
            cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 2) == 0), sp, bt, x, y);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_field.md
Name: note_field

Overview:
- Multi-lane successor to the single-note pixel bounds check.
- Holds one falling note per lane, advances all notes once per video frame, and scores player button presses against a hit window.
- Reports, with a fixed pipeline latency, whether the current VGA pixel lies inside any active note and in which lane.
- Sits between the PS/2 button decoder, the song sequencer (spawn pulses) and the VGA colour mux.

Parameters:
- NUM_LANES, 4, number of lanes/buttons (1..8).
- LANE_X0, 160, left x of lane 0 note (pixels).
- LANE_PITCH, 80, x spacing between adjacent lanes.
- NOTE_W, 40, note width and height (square), 1..127.
- SPEED, 4, pixels a note falls per frame_tick.
- HIT_Y, 400, y of hit line.
- HIT_TOL, 16, half-width of hit window.
- SCREEN_H, 480, visible height; note leaves screen when y >= SCREEN_H.
- SCORE_W, 16, score counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (vertical blank)
- spawn  in  NUM_LANES  one-cycle pulse per lane: start note at top
- button  in  NUM_LANES  one-cycle press pulses per lane (already edge-detected)
- curr_x  in  10  current pixel x
- curr_y  in  9  current pixel y
- in_note  out  1  pixel inside an active note (2-cycle latency)
- in_lane  out  3  lowest-index lane hit by the pixel; 0 when in_note=0
- hit  out  NUM_LANES  one-cycle pulse: successful hit on lane
- miss  out  NUM_LANES  one-cycle pulse: note expired on lane
- active  out  NUM_LANES  lane holds a live note
- score  out  SCORE_W  count of hits, saturating

Behaviour:
- Reset (synchronous, active-high), checked every edge, overrides all inputs. On reset: active=0, every note_y=0, hit=0, miss=0, score=0, in_note=0, in_lane=0, and both pipeline stages cleared. Reset mid-frame discards all notes; no miss pulses are generated.
- Per-lane state: active bit, note_y (9 bits). Lane x = LANE_X0 + i*LANE_PITCH, a compile-time constant.
- Lane state machine, two states:
  - IDLE (active=0) -> LIVE on spawn[i]; note_y loads 0.
  - LIVE + spawn[i]: spawn is ignored (one note per lane).
  - LIVE + frame_tick: next = note_y + SPEED, computed 10 bits wide. If next >= SCREEN_H: go to IDLE, pulse miss[i] next cycle. Otherwise note_y <= next.
  - LIVE + button[i] with HIT_Y-HIT_TOL <= note_y <= HIT_Y+HIT_TOL (signed-safe: lower bound clamps at 0): go to IDLE, pulse hit[i], score+1 (saturates at all ones).
  - Button outside the window, or on an IDLE lane: no effect, no penalty.
- Simultaneous events, same cycle, same lane:
  - button is evaluated against pre-tick note_y.
  - hit beats miss: a lane never pulses both.
  - spawn while the lane is leaving LIVE that cycle (hit or miss) is ignored.
  - Multiple lanes may hit in one cycle; score adds popcount(hits), saturating.
- hit/miss: registered, high exactly one cycle after the causing input edge.
- Pixel pipeline, strict inequalities, fixed latency 2:
  - Inside test per lane: active && curr_x > lane_x && curr_x < lane_x+NOTE_W (11-bit sum, no wrap) && curr_y > note_y && curr_y < note_y+NOTE_W (10-bit sum).
  - Stage 1 registers the per-lane inside vector.
  - Stage 2 priority-encodes it to in_note/in_lane.
  - Output at cycle t+2 reflects curr_x/curr_y and lane state sampled at t.
  - Notes partially below SCREEN_H still render until expiry.

Test Plan:
- Reset then spawn[0] -> active=0001, note_y0=0; 100 frame_ticks -> note_y0=400, no miss.
- At note_y0=400, button[0] -> hit=0001 one cycle later, score=1, active=0000; pixel (181,420) then gives in_note=0.
- Lane 1 live, 120 ticks (y=480) -> miss=0010 on the 120th tick's following cycle, active bit cleared, score unchanged; button[1] at y=200 -> nothing.
- Lane 2 at y=100, pixel (321,101) -> in_note=1, in_lane=2 exactly 2 cycles later; pixels (320,101) and (321,140) -> in_note=0 (strict edges).
- Lane 3 at y=384, frame_tick and button[3] in same cycle -> hit=1000, no miss, score+1; spawn[3] in the same cycle ignored.
- SCORE_W=2: 5 in-window hits -> score stays 3; assert reset mid-run -> all outputs 0 next cycle, no miss pulses.
